// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared types and constants for seq_adder_bcd_scan.
//   state_t       conversion FSM state
//   SEG_0..SEG_F  7-seg glyphs, bit order {dp,g,f,e,d,c,b,a}, active high
//   SEG_BLANK     all segments off
package seq_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_A     = 8'h77;
  localparam logic [7:0] SEG_B     = 8'h7C;
  localparam logic [7:0] SEG_C     = 8'h39;
  localparam logic [7:0] SEG_D     = 8'h5E;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seq_adder_bcd_scan_seg7.sv
// seg7_hex_decode: combinational nibble to 7-seg glyph.
//   nibble  in   4  value 0..F
//   seg     out  8  {dp,g,f,e,d,c,b,a}, active high, dp always 0
module seg7_hex_decode
  import seq_adder_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seq_adder_bcd_scan.sv
// seq_adder_bcd_scan: registered adder, serial binary-to-BCD (shift-add-3)
// and multiplexed common-select 7-seg driver.
//
//   state | meaning
//   IDLE  | waiting for start; result/cout hold last value
//   CONV  | shifting latched sum into BCD accumulator, WIDTH+1 cycles
//
// Ports:
//   clk, rst_n         clock (rising), async active-low reset
//   start              request, taken only when not busy
//   a, b, cin          operands, sampled with start
//   bcd_mode           1: decimal result, 0: zero-extended binary; sampled with start
//   ctrl_n             display enable, active low
//   busy, done         conversion in progress / one-cycle completion pulse
//   result, cout       last completed result and carry
//   seg, dig_sel       registered segment data and one-hot digit select
module seq_adder_bcd_scan
  import seq_adder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 16,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  cin,
  input  logic                  bcd_mode,
  input  logic                  ctrl_n,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int SW   = WIDTH + 1;
  localparam int RW   = 4 * DIGITS;
  localparam int CW   = $clog2(SW + 1);
  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (WIDTH < 2 || SCAN_DIV < 1 || 4 * DIGITS < SW || (10 ** DIGITS) <= (2 ** SW) - 1) begin : g_param_err
    $error("seq_adder_bcd_scan: DIGITS too small for WIDTH, or WIDTH/SCAN_DIV out of range");
  end

  state_t          state;
  logic [SW-1:0]   sum_in;
  logic [SW-1:0]   sum_q;
  logic [SW-1:0]   shreg;
  logic [RW-1:0]   acc;
  logic [RW-1:0]   acc_adj;
  logic [RW-1:0]   acc_next;
  logic            mode_q;
  logic [CW-1:0]   bit_cnt;

  assign sum_in = {1'b0, a} + {1'b0, b} + SW'(cin);

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    assign acc_adj[4*i +: 4] = (acc[4*i +: 4] > 4'd4) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end

  assign acc_next = {acc_adj[RW-2:0], shreg[SW-1]};

  // bit_cnt is a down-counter of remaining shifts; the last shift also
  // publishes the result so partial values never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      sum_q   <= '0;
      shreg   <= '0;
      acc     <= '0;
      mode_q  <= 1'b0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !busy) begin
            sum_q   <= sum_in;
            shreg   <= sum_in;
            acc     <= '0;
            mode_q  <= bcd_mode;
            bit_cnt <= CW'(SW);
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          acc     <= acc_next;
          shreg   <= {shreg[SW-2:0], 1'b0};
          bit_cnt <= bit_cnt - CW'(1);
          if (bit_cnt == CW'(1)) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= mode_q ? acc_next : RW'(sum_q);
            cout   <= sum_q[SW-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DIVW-1:0] div_cnt;
  logic [IW-1:0]   idx;
  logic [3:0]      nib_sel;
  logic [7:0]      seg_dec;
  logic [DIGITS:0] zero_above;
  logic            blank_sel;

  // zero_above[i]: digit i and every digit above it are zero
  assign zero_above[DIGITS] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    assign zero_above[i] = zero_above[i+1] && (result[4*i +: 4] == 4'd0);
  end

  always_comb begin
    nib_sel   = 4'd0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib_sel   = result[4*i +: 4];
        blank_sel = (BLANK_LZ != 0) && (i != 0) && zero_above[i];
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble (nib_sel),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
      seg     <= SEG_BLANK;
      dig_sel <= '0;
    end else begin
      if (div_cnt == DIVW'(SCAN_DIV - 1)) begin
        div_cnt <= '0;
        idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        div_cnt <= div_cnt + DIVW'(1);
      end
      if (ctrl_n) begin
        seg     <= SEG_BLANK;
        dig_sel <= '0;
      end else begin
        seg     <= blank_sel ? SEG_BLANK : seg_dec;
        dig_sel <= DIGITS'(1) << idx;
      end
    end
  end

endmodule

// File: tb/tb_seq_adder_bcd_scan.sv
module tb_seq_adder_bcd_scan;

  localparam int WIDTH    = 8;
  localparam int DIGITS   = 3;
  localparam int SCAN_DIV = 4;
  localparam int RW       = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              bcd_mode;
  logic              ctrl_n;
  logic              busy;
  logic              done;
  logic [RW-1:0]     result;
  logic              cout;
  logic [7:0]        seg;
  logic [DIGITS-1:0] dig_sel;

  seq_adder_bcd_scan #(
    .WIDTH    (WIDTH),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .bcd_mode (bcd_mode),
    .ctrl_n   (ctrl_n),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .seg      (seg),
    .dig_sel  (dig_sel)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  function automatic logic [RW-1:0] ref_result(input int s, input logic mode);
    logic [RW-1:0] v;
    int            rem;
    v   = '0;
    rem = s;
    if (mode) begin
      for (int k = 0; k < DIGITS; k++) begin
        v   = v | (RW'(rem % 10) << (4 * k));
        rem = rem / 10;
      end
    end else begin
      v = RW'(s);
    end
    return v;
  endfunction

  // Reference model: a request is taken whenever nothing is pending, and its
  // answer appears WIDTH+1 edges later. Display index is elapsed edges / SCAN_DIV.
  int            n_m, scan_t, due;
  logic          pend;
  logic [RW-1:0] m_result, p_result;
  logic          m_cout, p_cout;
  logic          e_busy, e_done;
  logic [7:0]    e_seg;
  logic [DIGITS-1:0] e_sel;

  always @(posedge clk or negedge rst_n) begin : model
    int nn, di, s;
    logic [RW-1:0] hi;
    if (!rst_n) begin
      n_m <= 0; scan_t <= 0; due <= 0; pend <= 1'b0;
      m_result <= '0; m_cout <= 1'b0; p_result <= '0; p_cout <= 1'b0;
      e_busy <= 1'b0; e_done <= 1'b0; e_seg <= 8'h00; e_sel <= '0;
    end else begin
      nn = n_m + 1;
      n_m <= nn;
      di = (scan_t / SCAN_DIV) % DIGITS;
      scan_t <= scan_t + 1;
      hi = m_result >> (4 * di);
      if (ctrl_n) begin
        e_seg <= 8'h00;
        e_sel <= '0;
      end else begin
        e_sel <= DIGITS'(1 << di);
        if (di > 0 && hi == 0) e_seg <= 8'h00;
        else                   e_seg <= glyph[hi[3:0]];
      end
      e_done <= 1'b0;
      if (pend && nn == due) begin
        m_result <= p_result;
        m_cout   <= p_cout;
        e_done   <= 1'b1;
        e_busy   <= 1'b0;
        pend     <= 1'b0;
      end else if (!pend && start) begin
        s = int'(a) + int'(b) + int'(cin);
        p_result <= ref_result(s, bcd_mode);
        p_cout   <= (s >= (1 << WIDTH));
        due      <= nn + WIDTH + 1;
        pend     <= 1'b1;
        e_busy   <= 1'b1;
      end
    end
  end

  logic chk_on = 1'b0;

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check_val("busy",    32'(busy),    32'(e_busy));
      check_val("done",    32'(done),    32'(e_done));
      check_val("result",  32'(result),  32'(m_result));
      check_val("cout",    32'(cout),    32'(m_cout));
      check_val("seg",     32'(seg),     32'(e_seg));
      check_val("dig_sel", 32'(dig_sel), 32'(e_sel));
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input logic op_cin, input logic op_mode, output int lat);
    @(negedge clk);
    a = op_a; b = op_b; cin = op_cin; bcd_mode = op_mode; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int  lat, cnt;
    logic seen1, seen2;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rm;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; bcd_mode = 1'b0; ctrl_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy",    32'(busy),    0);
    check_val("rst_done",    32'(done),    0);
    check_val("rst_result",  32'(result),  0);
    check_val("rst_seg",     32'(seg),     0);
    check_val("rst_dig_sel", 32'(dig_sel), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // decimal add with carry out
    run_op(8'd200, 8'd100, 1'b1, 1'b1, lat);
    check_val("t1_lat",    32'(lat),    9);
    check_val("t1_result", 32'(result), 32'h301);
    check_val("t1_cout",   32'(cout),   1);

    // hex mode, hex glyph on digit 1, leading zero blanked on digit 2
    run_op(8'hAB, 8'h01, 1'b0, 1'b0, lat);
    check_val("t2_lat",    32'(lat),    9);
    check_val("t2_result", 32'(result), 32'h0AC);
    check_val("t2_cout",   32'(cout),   0);
    seen1 = 1'b0; seen2 = 1'b0;
    for (int i = 0; i < 3 * SCAN_DIV + 2; i++) begin
      @(negedge clk);
      if (dig_sel == 3'b010 && !seen1) begin check_val("t2_dig1_A", 32'(seg), 32'h77); seen1 = 1'b1; end
      if (dig_sel == 3'b100 && !seen2) begin check_val("t2_dig2_blank", 32'(seg), 0); seen2 = 1'b1; end
    end
    check_val("t2_digits_seen", 32'({seen1, seen2}), 32'h3);

    // start held high with operands changing every cycle
    cnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); bcd_mode = 1'($urandom);
      @(negedge clk);
      if (done) cnt++;
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check_val("t3_dones", 32'(cnt), 2);

    // reset in the middle of a conversion
    @(negedge clk);
    a = 8'd55; b = 8'd66; cin = 1'b0; bcd_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("t4_busy",    32'(busy),    0);
    check_val("t4_done",    32'(done),    0);
    check_val("t4_result",  32'(result),  0);
    check_val("t4_cout",    32'(cout),    0);
    check_val("t4_seg",     32'(seg),     0);
    check_val("t4_dig_sel", 32'(dig_sel), 0);
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check_val("t4_no_done", 32'(cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd99, 8'd1, 1'b1, 1'b1, lat);
    check_val("t4_lat",    32'(lat),    9);
    check_val("t4_after",  32'(result), 32'h101);

    // 007 scanning pattern
    run_op(8'd3, 8'd4, 1'b0, 1'b1, lat);
    check_val("t5_result", 32'(result), 32'h007);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (dig_sel == 3'b001) check_val("t5_seg_d0", 32'(seg), 32'h07);
      else                   check_val("t5_seg_hi", 32'(seg), 0);
    end

    // display disabled mid-scan
    @(negedge clk);
    ctrl_n = 1'b1;
    repeat (10) @(negedge clk);
    ctrl_n = 1'b0;
    repeat (14) @(negedge clk);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) == 0);
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      cin      = 1'($urandom);
      bcd_mode = 1'($urandom);
      ctrl_n   = ($urandom_range(0, 15) == 0);
    end
    start = 1'b0; ctrl_n = 1'b0;
    repeat (15) @(negedge clk);

    // directed random operands compared to plain arithmetic
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom); rm = 1'($urandom);
      run_op(ra, rb, rc, rm, lat);
      check_val("rnd_lat",    32'(lat),    9);
      check_val("rnd_result", 32'(result), 32'(ref_result(int'(ra) + int'(rb) + int'(rc), rm)));
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
